jk_register_arbiter: RTL and testbench
======================================

JK_REGISTER_ARBITER -- requirements
Module: jk_register_arbiter

Interface
REQ-001 Parameter W SHALL default to 8 and set the width of the shared JK register.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-004 req_a  input  1  requester A operation request, a level held until ack_a.
REQ-005 op_a  input  2  requester A opcode: 00 CLEAR, 01 SET, 10 TOGGLE, 11 LOAD.
REQ-006 data_a  input  W  requester A operand: bit mask for CLEAR/SET/TOGGLE, value for LOAD.
REQ-007 ack_a  output  1  one-cycle completion pulse to requester A.
REQ-008 req_b, op_b, data_b, ack_b SHALL behave as the A ports, for requester B.
REQ-009 q  output  W  present state of the shared JK register.
REQ-010 j, k  output  W each  JK excitation vectors applied this cycle; 0 whenever no operation is being applied.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 last_grant  output  1  0 = A served last, 1 = B served last.

Function
REQ-013 The register SHALL hold W JK flip-flops with per-bit next state q+ = (j & ~q) | (~k & q).
REQ-014 Excitation from the granted operand d SHALL be: CLEAR j=0, k=d; SET j=d, k=0; TOGGLE j=d, k=d; LOAD j=d, k=~d.
REQ-015 The FSM SHALL have three states (IDLE, APPLY, ACK) with transitions IDLE->APPLY when any req is high, APPLY->ACK unconditionally, and ACK->IDLE unconditionally.
REQ-016 In IDLE, the grant SHALL go to the only requester asserting req, and the grantee's op and data SHALL be latched at that edge.
REQ-017 When both reqs are high in IDLE, the grant SHALL go to the requester not named by last_grant (round-robin).
REQ-018 last_grant SHALL update to the grantee on the IDLE->APPLY edge.
REQ-019 In APPLY, j and k SHALL carry the latched excitation, and q SHALL take the new value at the APPLY->ACK edge.
REQ-020 In ACK, exactly one of ack_a/ack_b (the grantee) SHALL be high for one cycle, and q SHALL already show the result.
REQ-021 Latency SHALL be req sampled at edge 0, q updated at edge 1, ack high during cycle 2; the minimum request spacing is three cycles.
REQ-022 A requester SHALL deassert req on the edge ending its ack cycle; the arbiter SHALL NOT re-sample req in ACK.
REQ-023 Once granted, an operation SHALL complete and be acknowledged even if req drops early.
REQ-024 Changes to op or data after the grant edge SHALL NOT affect the operation in progress.
REQ-025 A non-granted requester SHALL wait with req held and SHALL NOT receive ack.
REQ-026 ack_a and ack_b SHALL never be high simultaneously.
REQ-027 A zero operand SHALL be a legal no-op that still completes the full three-state handshake.

Reset
REQ-028 With reset high at an edge, the block SHALL set state=IDLE, q=0, j=0, k=0, ack_a=0, ack_b=0, busy=0, last_grant=1, so that A wins the first tie.
REQ-029 Reset asserted in APPLY or ACK SHALL abort the operation: no ack is issued, and q=0 takes precedence over the in-flight update.
REQ-030 Requests present while reset is high SHALL be ignored and SHALL be evaluated in the first IDLE cycle after reset deasserts.

Verification (W=8)
REQ-031 Reset, then req_a with LOAD 0xA5 -> j=0xA5 and k=0x5A in APPLY; q=0xA5 and ack_a=1 in the next cycle; busy high for two cycles.
REQ-032 From q=0xA5, A TOGGLE 0x0F, then B CLEAR 0xF0, then A SET 0x03 -> q=0xAA, then 0x0A, then 0x0B; each ack goes only to the issuing requester.
REQ-033 Both reqs high continuously after reset -> grants alternate A, B, A, B; last_grant toggles after every grant; no ack overlap.
REQ-034 Grant A, then change data_a and drop req_a in APPLY -> the originally latched operation is applied and ack_a still pulses.
REQ-035 Assert reset during APPLY of LOAD 0xFF -> q=0 next cycle, no ack, busy=0; a pending req_b is served first after reset, since B is the only requester.
REQ-036 B issues SET 0x00 with q=0x3C -> q stays 0x3C, ack_b pulses at cycle 2.

Source files
------------

// File: rtl/jk_register_arbiter.sv
// Two-requester round-robin arbiter in front of a shared W-bit JK register.
// Each granted operation runs IDLE -> APPLY -> ACK, so requests are served at most once every three cycles.
module jk_register_arbiter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_a,
    input  logic [1:0]   op_a,
    input  logic [W-1:0] data_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [1:0]   op_b,
    input  logic [W-1:0] data_b,
    output logic         ack_b,
    output logic [W-1:0] q,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    state_t       state;
    state_t       state_nxt;
    logic         grant;      // 0 = A owns the operation in flight, 1 = B
    logic         grant_nxt;
    logic         take;
    logic [1:0]   op_sel;
    logic [W-1:0] data_sel;
    logic [W-1:0] j_lat;
    logic [W-1:0] k_lat;
    logic [W-1:0] j_nxt;
    logic [W-1:0] k_nxt;

    // Excitation packed as {j, k} for the granted opcode and operand.
    function automatic logic [2*W-1:0] excite(input logic [1:0] op, input logic [W-1:0] d);
        logic [2*W-1:0] jk;
        jk = '0;
        case (op)
            OP_CLEAR:  jk = {{W{1'b0}}, d};
            OP_SET:    jk = {d, {W{1'b0}}};
            OP_TOGGLE: jk = {d, d};
            OP_LOAD:   jk = {d, ~d};
            default:   jk = '0;
        endcase
        return jk;
    endfunction

    function automatic logic [W-1:0] jk_next(input logic [W-1:0] qv,
                                             input logic [W-1:0] jv,
                                             input logic [W-1:0] kv);
        return (jv & ~qv) | (~kv & qv);
    endfunction

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nxt = APPLY;
                    take      = 1'b1;
                    // On a tie the requester not served last wins; otherwise the lone requester.
                    grant_nxt = (req_a && req_b) ? ~last_grant : req_b;
                end
            end
            APPLY:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign op_sel         = grant_nxt ? op_b : op_a;
    assign data_sel       = grant_nxt ? data_b : data_a;
    assign {j_nxt, k_nxt} = excite(op_sel, data_sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            j_lat      <= '0;
            k_lat      <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                grant      <= grant_nxt;
                last_grant <= grant_nxt;
                j_lat      <= j_nxt;
                k_lat      <= k_nxt;
            end
            if (state == APPLY) begin
                q <= jk_next(q, j_lat, k_lat);
            end
        end
    end

    always_comb begin
        j     = '0;
        k     = '0;
        ack_a = 1'b0;
        ack_b = 1'b0;
        busy  = (state != IDLE);
        if (state == APPLY) begin
            j = j_lat;
            k = k_lat;
        end
        if (state == ACK) begin
            ack_a = ~grant;
            ack_b = grant;
        end
    end

endmodule

// File: tb/tb_jk_register_arbiter.sv
// Directed bench for jk_register_arbiter: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares whenever an ack appears.
module tb_jk_register_arbiter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_a, req_b;
    logic [1:0]   op_a, op_b;
    logic [W-1:0] data_a, data_b;
    logic         ack_a, ack_b;
    logic [W-1:0] q, j, k;
    logic         busy, last_grant;

    typedef struct packed {
        logic         who;
        logic [W-1:0] qv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    jk_register_arbiter #(.W(W)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .op_a(op_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .data_b(data_b), .ack_b(ack_b),
        .q(q), .j(j), .k(k), .busy(busy), .last_grant(last_grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every ack cycle must match the oldest expected completion.
    always @(negedge clock) begin
        if (ack_a || ack_b) begin
            exp_t e;
            chk("ack_overlap", {31'd0, ack_a && ack_b}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'd0, ack_b}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {31'd0, ack_b}, {31'd0, e.who});
                chk("q_at_ack", {24'd0, q}, {24'd0, e.qv});
            end
        end
    end

    // Full handshake for one requester; req drops on the edge ending its ack cycle.
    task automatic run_op(input logic who, input logic [1:0] op, input logic [W-1:0] d,
                          input logic [W-1:0] expq);
        bit got;
        if (who) begin req_b = 1'b1; op_b = op; data_b = d; end
        else     begin req_a = 1'b1; op_a = op; data_a = d; end
        sb.push_back('{who: who, qv: expq});
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (who ? ack_b : ack_a) got = 1'b1;
        end
        chk("ack_timeout", {31'd0, got}, 32'd1);
        step();
        if (who) req_b = 1'b0;
        else     req_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0; op_a = 2'b00; data_a = '0;
        req_b = 1'b0; op_b = 2'b00; data_b = '0;
        step();
        step();
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_jk", {16'd0, j, k}, 32'h0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, ack_a, ack_b}, 32'd0);
        chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
        reset = 1'b0;

        // A LOAD 0xA5, stepped cycle by cycle.
        req_a = 1'b1; op_a = 2'b11; data_a = 8'hA5;
        sb.push_back('{who: 1'b0, qv: 8'hA5});
        step();
        chk("load_j", {24'd0, j}, 32'hA5);
        chk("load_k", {24'd0, k}, 32'h5A);
        chk("load_busy_apply", {31'd0, busy}, 32'd1);
        chk("load_last_grant", {31'd0, last_grant}, 32'd0);
        step();
        chk("load_busy_ack", {31'd0, busy}, 32'd1);
        chk("load_ack_a", {31'd0, ack_a}, 32'd1);
        chk("load_jk_ack", {16'd0, j, k}, 32'h0000);
        step();
        req_a = 1'b0;
        chk("load_idle_busy", {31'd0, busy}, 32'd0);

        run_op(1'b0, 2'b10, 8'h0F, 8'hAA);
        run_op(1'b1, 2'b00, 8'hF0, 8'h0A);
        run_op(1'b0, 2'b01, 8'h03, 8'h0B);
        chk("seq_q", {24'd0, q}, 32'h0B);

        // Operand change and early req drop after the grant must not matter.
        req_a = 1'b1; op_a = 2'b10; data_a = 8'hFF;
        sb.push_back('{who: 1'b0, qv: 8'hF4});
        step();
        op_a = 2'b11; data_a = 8'h00; req_a = 1'b0;
        chk("latch_j", {24'd0, j}, 32'hFF);
        chk("latch_k", {24'd0, k}, 32'hFF);
        step();
        chk("latch_ack_a", {31'd0, ack_a}, 32'd1);
        step();
        chk("latch_q", {24'd0, q}, 32'hF4);

        run_op(1'b0, 2'b11, 8'h3C, 8'h3C);
        run_op(1'b1, 2'b01, 8'h00, 8'h3C);

        // Reset during APPLY aborts; B pending through reset is served afterwards.
        req_a = 1'b1; op_a = 2'b11; data_a = 8'hFF;
        step();
        chk("abort_apply_j", {24'd0, j}, 32'hFF);
        reset = 1'b1; req_a = 1'b0;
        req_b = 1'b1; op_b = 2'b01; data_b = 8'h81;
        step();
        chk("abort_q", {24'd0, q}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_acks", {30'd0, ack_a, ack_b}, 32'd0);
        chk("abort_last_grant", {31'd0, last_grant}, 32'd1);
        step();
        chk("hold_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        run_op(1'b1, 2'b01, 8'h81, 8'h81);

        // Both requesters held continuously: strict alternation starting with A.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a = 1'b1; op_a = 2'b10; data_a = 8'h01;
        req_b = 1'b1; op_b = 2'b10; data_b = 8'h02;
        sb.push_back('{who: 1'b0, qv: 8'h01});
        sb.push_back('{who: 1'b1, qv: 8'h03});
        sb.push_back('{who: 1'b0, qv: 8'h02});
        sb.push_back('{who: 1'b1, qv: 8'h00});
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s % 3 == 1)
                chk("rr_last_grant", {31'd0, last_grant}, ((s - 1) / 3) % 2);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        step();
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
